// File: rtl/chan_mux_pkg.sv
// Shared encodings for the channel scan multiplexer: mode input values and FSM states.
package chan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic {
    MANUAL = 1'b0,
    SCAN   = 1'b1
  } state_t;

endpackage

// File: rtl/chan_scan_mux_scan_counter.sv
// Dwell counter plus wrapping channel pointer for auto-scan mode.
// tick marks the last dwell cycle; the pointer advances only on an enabled tick.
module scan_counter #(
  parameter int  NUM_CH = 6,
  parameter int  DWELL  = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  output logic             tick,
  output logic [SEL_W-1:0] ptr
);

  // DWELL=1 still needs a one-bit counter; it simply never leaves zero.
  localparam int               CNT_W    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] PTR_LAST = SEL_W'(NUM_CH - 1);

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      ptr <= '0;
    end else if (clear) begin
      cnt <= '0;
      ptr <= '0;
    end else if (enable) begin
      if (tick) begin
        cnt <= '0;
        ptr <= (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/chan_scan_mux.sv
// Registered N:1 channel selector with manual select and auto-scan modes,
// delivering a channel-tagged word over a valid/ready handshake.
//
//   state  | meaning
//   MANUAL | sel picks the channel; capture on every free cycle
//   SCAN   | pointer walks all channels, one capture per DWELL cycles
module chan_scan_mux
  import chan_mux_pkg::*;
#(
  parameter int  NUM_CH = 6,
  parameter int  WIDTH  = 4,
  parameter int  DWELL  = 4,
  localparam int SEL_W  = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    mode,
  input  logic [SEL_W-1:0]        sel,
  input  logic [NUM_CH*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_ch,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  localparam logic [SEL_W:0] NUM_CH_EXT = (SEL_W + 1)'(NUM_CH);

  state_t             state_q, state_d;
  logic               free;
  logic               take_manual, take_scan, capture;
  logic               cnt_enable, cnt_clear;
  logic               tick;
  logic [SEL_W-1:0]   ptr;
  logic               sel_in_range;
  logic [WIDTH-1:0]   manual_word, scan_word;
  logic [WIDTH-1:0]   cap_data;
  logic [SEL_W-1:0]   cap_ch;
  logic               cap_err;

  assign free         = !out_valid || out_ready;
  assign sel_in_range = ({1'b0, sel} < NUM_CH_EXT);

  always_comb begin
    manual_word = '0;
    scan_word   = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (sel == SEL_W'(k)) manual_word = data_in[k*WIDTH +: WIDTH];
      if (ptr == SEL_W'(k)) scan_word   = data_in[k*WIDTH +: WIDTH];
    end
  end

  scan_counter #(
    .NUM_CH (NUM_CH),
    .DWELL  (DWELL)
  ) u_scan_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (cnt_enable),
    .clear  (cnt_clear),
    .tick   (tick),
    .ptr    (ptr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= MANUAL;
    else        state_q <= state_d;
  end

  // Mode is acted on in the cycle it is seen; only entry into scan costs a cycle.
  always_comb begin
    state_d     = state_q;
    take_manual = 1'b0;
    take_scan   = 1'b0;
    cnt_enable  = 1'b0;
    cnt_clear   = 1'b0;
    case (state_q)
      MANUAL: begin
        if (mode == MODE_SCAN) begin
          state_d   = SCAN;
          cnt_clear = 1'b1;
        end else begin
          take_manual = 1'b1;
        end
      end
      SCAN: begin
        if (mode == MODE_MANUAL) begin
          state_d     = MANUAL;
          take_manual = 1'b1;
        end else begin
          cnt_enable = !tick || free;
          take_scan  = tick;
        end
      end
      default: state_d = MANUAL;
    endcase
  end

  always_comb begin
    capture  = free && (take_manual || take_scan);
    cap_data = '0;
    cap_ch   = '0;
    cap_err  = 1'b0;
    if (take_scan) begin
      cap_data = scan_word;
      cap_ch   = ptr;
    end else if (take_manual) begin
      cap_data = sel_in_range ? manual_word : '0;
      cap_ch   = sel;
      cap_err  = !sel_in_range;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      sel_err   <= 1'b0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= cap_data;
      out_ch    <= cap_ch;
      sel_err   <= cap_err;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed plus randomized bench for chan_scan_mux against a behavioural model.
module tb_chan_scan_mux;

  localparam int NUM_CH = 6;
  localparam int WIDTH  = 4;
  localparam int DWELL  = 4;
  localparam int SEL_W  = 3;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    mode = 1'b0;
  logic [SEL_W-1:0]        sel = '0;
  logic [NUM_CH*WIDTH-1:0] data_in = '0;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_ch;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic                    sel_err;

  int checks = 0;
  int errors = 0;

  bit m_valid, m_err, m_scanning;
  int m_data, m_ch, m_ptr, m_cnt;

  always #5 clk = ~clk;

  chan_scan_mux #(.NUM_CH(NUM_CH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .data_in   (data_in),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sel_err   (sel_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int word_of(input int k);
    return int'((data_in >> (k * WIDTH)) & ((1 << WIDTH) - 1));
  endfunction

  task automatic model_reset();
    m_valid = 0; m_err = 0; m_scanning = 0;
    m_data = 0; m_ch = 0; m_ptr = 0; m_cnt = 0;
  endtask

  // One clock of the spec rules, using the inputs present at the edge.
  task automatic model_update();
    bit free, cap, e;
    int d, c;
    if (!rst_n) begin
      model_reset();
      return;
    end
    free = !m_valid || out_ready;
    cap = 0; d = 0; c = 0; e = 0;
    if (mode == 1'b0) begin
      m_scanning = 0;
      if (free) begin
        cap = 1;
        c = int'(sel);
        e = (int'(sel) >= NUM_CH);
        d = e ? 0 : word_of(int'(sel));
      end
    end else if (!m_scanning) begin
      m_scanning = 1;
      m_ptr = 0;
      m_cnt = 0;
    end else if (m_cnt < DWELL - 1) begin
      m_cnt++;
    end else if (free) begin
      cap = 1;
      c = m_ptr;
      d = word_of(m_ptr);
      m_cnt = 0;
      m_ptr = (m_ptr + 1) % NUM_CH;
    end
    if (cap) begin
      m_valid = 1; m_data = d; m_ch = c; m_err = e;
    end else if (out_ready) begin
      m_valid = 0;
    end
  endtask

  task automatic check_outputs(input string where);
    chk({where, "_valid"}, 32'(out_valid), 32'(m_valid));
    chk({where, "_data"},  32'(out_data),  32'(m_data));
    chk({where, "_ch"},    32'(out_ch),    32'(m_ch));
    chk({where, "_err"},   32'(sel_err),   32'(m_err));
  endtask

  task automatic step(input string where);
    @(posedge clk);
    model_update();
    #1;
    check_outputs(where);
  endtask

  initial begin
    int seen[$];
    bit found;
    int sweep[3] = '{0, 2, 4};

    model_reset();
    data_in = {4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0};
    #1;
    check_outputs("reset");
    repeat (2) step("reset");
    #2 rst_n = 1'b1;

    out_ready = 1'b1;
    foreach (sweep[i]) begin
      sel = SEL_W'(sweep[i]);
      step("sweep");
      chk("sweep_sel_data", 32'(out_data), 32'(sweep[i]));
      chk("sweep_sel_ch", 32'(out_ch), 32'(sweep[i]));
      repeat (19) step("sweep");
    end

    sel = 3'd6;
    step("oor");
    chk("oor6_data", 32'(out_data), 0);
    chk("oor6_err", 32'(sel_err), 1);
    sel = 3'd7;
    step("oor");
    chk("oor7_ch", 32'(out_ch), 7);
    chk("oor7_err", 32'(sel_err), 1);
    sel = 3'd3;
    step("oor");
    chk("inrange3_data", 32'(out_data), 3);
    chk("inrange3_err", 32'(sel_err), 0);

    mode = 1'b1;
    for (int i = 0; i < 30; i++) begin
      step("wrap");
      if (out_valid) seen.push_back(int'(out_ch));
    end
    chk("wrap_count", 32'(seen.size()), 7);
    for (int i = 0; i < 7; i++)
      if (i < seen.size()) chk("wrap_seq", 32'(seen[i]), 32'(i % NUM_CH));

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      step("bp_wait");
      if (out_valid && out_ch == 3'd2) found = 1;
    end
    chk("bp_found_ch2", 32'(found), 1);
    out_ready = 1'b0;
    repeat (10) step("bp_hold");
    chk("bp_hold_data", 32'(out_data), 2);
    chk("bp_hold_valid", 32'(out_valid), 1);
    out_ready = 1'b1;
    step("bp_release");
    chk("bp_next_ch3", 32'(out_ch), 3);
    repeat (DWELL) step("bp_after");
    chk("bp_next_ch4", 32'(out_ch), 4);

    mode = 1'b0;
    sel = 3'd5;
    repeat (3) step("sw_manual");
    chk("sw_manual_data", 32'(out_data), 5);
    mode = 1'b1;
    repeat (DWELL) step("sw_scan");
    chk("sw_not_yet", 32'(out_valid), 0);
    step("sw_scan");
    chk("sw_first_ch0", 32'(out_ch), 0);
    chk("sw_first_valid", 32'(out_valid), 1);
    mode = 1'b0;
    sel = 3'd1;
    step("sw_back");
    chk("sw_back_data", 32'(out_data), 1);

    mode = 1'b1;
    out_ready = 1'b0;
    repeat (DWELL + 4) step("stall");
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("async_rst");
    repeat (2) step("in_rst");
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (DWELL + 1) step("post_rst");
    chk("post_rst_ch0", 32'(out_ch), 0);
    chk("post_rst_valid", 32'(out_valid), 1);

    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      sel = SEL_W'($urandom_range(0, 7));
      data_in = (NUM_CH*WIDTH)'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
